// File: rtl/poly_mul_pkg.sv
// Shared constants and FSM encoding for the polynomial multiplier slice.
// The bank loader and the multiplier top both import this package.
package poly_mul_pkg;

    localparam int unsigned DEF_N     = 1024;
    localparam int unsigned DEF_BANKS = 8;
    localparam int unsigned DEF_DEPTH = 128;
    localparam int unsigned DEF_W     = 256;

    localparam int unsigned DEF_AW = $clog2(DEF_DEPTH);
    localparam int unsigned DEF_CW = $clog2(DEF_N);
    localparam int unsigned DEF_BW = $clog2(DEF_BANKS);

    typedef enum logic [2:0] {
        StIdle,
        StLoadA,
        StLoadB,
        StStart,
        StWaitDone
    } state_e;

endpackage

// File: rtl/poly_bank_loader_if.sv
// Coefficient stream into the bank loader: valid/ready with a last marker.
interface poly_bank_loader_if
    import poly_mul_pkg::*;
#(
    parameter int unsigned W = DEF_W
) ();

    logic         in_valid;
    logic [W-1:0] in_data;
    logic         in_last;
    logic         in_ready;

    modport master (
        output in_valid,
        output in_data,
        output in_last,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  in_last,
        output in_ready
    );

endinterface

// File: rtl/poly_bank_loader.sv
// Streams two N-coefficient operands into interleaved A/B banks, then kicks
// the polynomial multiplier and waits for its completion.
module poly_bank_loader
    import poly_mul_pkg::*;
#(
    parameter  int unsigned N     = DEF_N,
    parameter  int unsigned BANKS = DEF_BANKS,
    parameter  int unsigned DEPTH = DEF_DEPTH,
    parameter  int unsigned W     = DEF_W,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              go,
    poly_bank_loader_if.slave strm,
    output logic [BANKS-1:0]  wr_en_a,
    output logic [BANKS-1:0]  wr_en_b,
    output logic [AW-1:0]     wr_addr,
    output logic [W-1:0]      wr_data,
    output logic              mul_start,
    input  logic              mul_done,
    output logic              busy,
    output logic              err
);

    localparam int unsigned CW = $clog2(N);
    localparam int unsigned BW = $clog2(BANKS);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             accept;
    logic [BANKS-1:0] bank_sel;
    logic [BANKS-1:0] wr_en_a_q, wr_en_b_q;
    logic [AW-1:0]    wr_addr_q;
    logic [W-1:0]     wr_data_q;

    assign strm.in_ready = (state_q == StLoadA) || (state_q == StLoadB);
    assign accept        = strm.in_valid && strm.in_ready;

    // Low index bits pick the bank, high bits the word within it.
    assign bank_sel = BANKS'(1) << cnt_q[BW-1:0];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        mul_start = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (go) begin
                    state_d = StLoadA;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                end
            end
            StLoadA, StLoadB: begin
                if (accept) begin
                    if (cnt_q == CW'(N - 1)) begin
                        cnt_d   = '0;
                        state_d = (state_q == StLoadA) ? StLoadB : StStart;
                    end else if (strm.in_last) begin
                        cnt_d   = '0;
                        err_d   = 1'b1;
                        state_d = StIdle;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            StStart: begin
                // Hold off the kick until the final B word has been written.
                if (wr_en_b_q == '0) begin
                    mul_start = 1'b1;
                    state_d   = StWaitDone;
                end
            end
            StWaitDone: begin
                if (mul_done) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            wr_en_a_q <= '0;
            wr_en_b_q <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            wr_en_a_q <= (accept && state_q == StLoadA) ? bank_sel : '0;
            wr_en_b_q <= (accept && state_q == StLoadB) ? bank_sel : '0;
            if (accept) begin
                wr_addr_q <= cnt_q[CW-1:BW];
                wr_data_q <= strm.in_data;
            end
        end
    end

    assign wr_en_a = wr_en_a_q;
    assign wr_en_b = wr_en_b_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign busy    = (state_q != StIdle);
    assign err     = err_q;

endmodule

// File: tb/tb_poly_bank_loader.sv
// Randomised bench for poly_bank_loader: a phase-level reference model is
// compared against the DUT on every cycle, plus literal bank-content checks.
module tb_poly_bank_loader;
    import poly_mul_pkg::*;

    localparam int unsigned N     = DEF_N;
    localparam int unsigned BANKS = DEF_BANKS;
    localparam int unsigned DEPTH = DEF_DEPTH;
    localparam int unsigned W     = DEF_W;
    localparam int unsigned AW    = $clog2(DEPTH);

    localparam int PH_IDLE  = 0;
    localparam int PH_A     = 1;
    localparam int PH_B     = 2;
    localparam int PH_DRAIN = 3;
    localparam int PH_START = 4;
    localparam int PH_WAIT  = 5;

    logic             clk = 1'b0;
    logic             rst;
    logic             go;
    logic             mul_done;
    logic [BANKS-1:0] wr_en_a;
    logic [BANKS-1:0] wr_en_b;
    logic [AW-1:0]    wr_addr;
    logic [W-1:0]     wr_data;
    logic             mul_start;
    logic             busy;
    logic             err;

    poly_bank_loader_if #(.W(W)) strm ();

    poly_bank_loader #(
        .N    (N),
        .BANKS(BANKS),
        .DEPTH(DEPTH),
        .W    (W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .go       (go),
        .strm     (strm),
        .wr_en_a  (wr_en_a),
        .wr_en_b  (wr_en_b),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .mul_start(mul_start),
        .mul_done (mul_done),
        .busy     (busy),
        .err      (err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int n_start = 0;
    int n_wr    = 0;

    logic [W-1:0] mem_a [BANKS][DEPTH];
    logic [W-1:0] mem_b [BANKS][DEPTH];

    // Reference model: which phase of the job we are in and what write is due.
    bit           m_valid    = 1'b0;
    int           m_phase    = PH_IDLE;
    int           m_idx      = 0;
    bit           m_err      = 1'b0;
    bit           m_pend     = 1'b0;
    bit           m_pend_b   = 1'b0;
    int           m_pend_idx = 0;
    logic [W-1:0] m_pend_data;
    logic [BANKS-1:0] ea, eb;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int coef(input int s);
        return (s < int'(N)) ? s : 1000 + s - int'(N);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_valid  = 1'b1;
            m_phase  = PH_IDLE;
            m_idx    = 0;
            m_err    = 1'b0;
            m_pend   = 1'b0;
        end else begin
            m_pend = 1'b0;
            case (m_phase)
                PH_IDLE: if (go) begin
                    m_phase = PH_A;
                    m_idx   = 0;
                    m_err   = 1'b0;
                end
                PH_A, PH_B: if (strm.in_valid) begin
                    m_pend      = 1'b1;
                    m_pend_b    = (m_phase == PH_B);
                    m_pend_idx  = m_idx;
                    m_pend_data = strm.in_data;
                    if (m_idx == int'(N) - 1) begin
                        m_phase = (m_phase == PH_A) ? PH_B : PH_DRAIN;
                        m_idx   = 0;
                    end else if (strm.in_last) begin
                        m_err   = 1'b1;
                        m_phase = PH_IDLE;
                    end else begin
                        m_idx++;
                    end
                end
                PH_DRAIN: m_phase = PH_START;
                PH_START: m_phase = PH_WAIT;
                PH_WAIT:  if (mul_done) m_phase = PH_IDLE;
                default:  m_phase = PH_IDLE;
            endcase
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            ea = '0;
            eb = '0;
            if (m_pend && !m_pend_b) ea[m_pend_idx % BANKS] = 1'b1;
            if (m_pend && m_pend_b)  eb[m_pend_idx % BANKS] = 1'b1;
            check("in_ready", W'(strm.in_ready), W'(m_phase == PH_A || m_phase == PH_B));
            check("busy", W'(busy), W'(m_phase != PH_IDLE));
            check("err", W'(err), W'(m_err));
            check("mul_start", W'(mul_start), W'(m_phase == PH_START));
            check("wr_en_a", W'(wr_en_a), W'(ea));
            check("wr_en_b", W'(wr_en_b), W'(eb));
            if (m_pend) begin
                check("wr_addr", W'(wr_addr), W'(m_pend_idx / BANKS));
                check("wr_data", wr_data, m_pend_data);
            end
        end
        if (mul_start) n_start++;
        if (wr_en_a != '0 || wr_en_b != '0) n_wr++;
        for (int b = 0; b < int'(BANKS); b++) begin
            if (wr_en_a[b]) mem_a[b][wr_addr] = wr_data;
            if (wr_en_b[b]) mem_b[b][wr_addr] = wr_data;
        end
    end

    task automatic clear_mems();
        for (int b = 0; b < int'(BANKS); b++) begin
            for (int a = 0; a < int'(DEPTH); a++) begin
                mem_a[b][a] = '1;
                mem_b[b][a] = '1;
            end
        end
    endtask

    task automatic check_mem(input string name, input bit is_b);
        int bad;
        logic [W-1:0] got;
        bad = 0;
        for (int i = 0; i < int'(N); i++) begin
            got = is_b ? mem_b[i % BANKS][i / BANKS] : mem_a[i % BANKS][i / BANKS];
            if (got !== W'(is_b ? coef(i + int'(N)) : coef(i))) bad++;
        end
        check(name, W'(bad), W'(0));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, W'(strm.in_ready), W'(0));
        check({tag, "_wr_en_a"}, W'(wr_en_a), W'(0));
        check({tag, "_wr_en_b"}, W'(wr_en_b), W'(0));
        check({tag, "_wr_addr"}, W'(wr_addr), W'(0));
        check({tag, "_wr_data"}, wr_data, W'(0));
        check({tag, "_mul_start"}, W'(mul_start), W'(0));
        check({tag, "_busy"}, W'(busy), W'(0));
        check({tag, "_err"}, W'(err), W'(0));
    endtask

    // One job: pulse go, stream A then B (stream indices 0..2N-1), optional
    // early in_last, reset injection, and ignored go/mul_done noise.
    task automatic run_job(input int gap, input int last_at, input int rst_at, input bit noise,
                           output int lat);
        int sidx, cyc, stop_cyc;
        bit rdy, done, stopped, did_done, did_go, rst_seen;
        sidx = 0; cyc = 0; lat = -1; stop_cyc = 0;
        done = 1'b0; stopped = 1'b0; did_done = 1'b0; did_go = 1'b0; rst_seen = 1'b0;
        @(posedge clk); #1;
        go = 1'b1;
        @(negedge clk);
        rdy = strm.in_ready;
        while (!done && cyc < 20000) begin
            @(posedge clk); #1;
            cyc++;
            go       = 1'b0;
            mul_done = 1'b0;
            if (rst) begin
                rst           = 1'b0;
                strm.in_valid = 1'b0;
                strm.in_last  = 1'b0;
                rst_seen      = 1'b1;
                done          = 1'b1;
            end else begin
                if (strm.in_valid && rdy) begin
                    if (sidx == last_at) begin
                        stopped  = 1'b1;
                        stop_cyc = cyc;
                    end
                    sidx++;
                end
                if (noise && sidx == 100 && !did_done) begin
                    mul_done = 1'b1;
                    did_done = 1'b1;
                end
                if (noise && sidx == int'(N) + 300 && !did_go) begin
                    go     = 1'b1;
                    did_go = 1'b1;
                end
                if (lat >= 0) begin
                    if (noise && cyc - lat == 1) go = 1'b1;
                    if (cyc - lat == 4) mul_done = 1'b1;
                end
                if (stopped && cyc - stop_cyc >= 3) done = 1'b1;
                if (!stopped && sidx < 2 * int'(N)) begin
                    strm.in_valid = (gap == 0) || ($urandom_range(0, 99) >= gap);
                    strm.in_data  = W'(coef(sidx));
                    strm.in_last  = (sidx == int'(N) - 1) || (sidx == 2 * int'(N) - 1) ||
                                    (sidx == last_at);
                    if (sidx == rst_at) begin
                        rst           = 1'b1;
                        strm.in_valid = 1'b1;
                    end
                end else begin
                    strm.in_valid = 1'b0;
                    strm.in_last  = 1'b0;
                end
            end
            @(negedge clk);
            rdy = strm.in_ready;
            if (rst_seen) check_reset_outputs("mid_load_reset");
            if (mul_start && lat < 0) lat = cyc;
            if (lat >= 0 && cyc - lat > 5 && !busy) done = 1'b1;
        end
        if (!done) check("job_timeout", W'(1), W'(0));
    endtask

    initial begin
        int lat, s0, w0;
        rst           = 1'b1;
        go            = 1'b0;
        mul_done      = 1'b0;
        strm.in_valid = 1'b0;
        strm.in_data  = '0;
        strm.in_last  = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        // Back-to-back streaming.
        clear_mems();
        s0 = n_start;
        run_job(0, -1, -1, 1'b0, lat);
        check("a_bank3_addr5", mem_a[3][5], W'(43));
        check("b_bank7_addr127", mem_b[7][127], W'(2023));
        check("start_latency", W'(lat), W'(2 * N + 2));
        check("start_pulses_job1", W'(n_start - s0), W'(1));
        check_mem("a_contents_b2b", 1'b0);
        check_mem("b_contents_b2b", 1'b1);

        // 30% idle gaps plus go/mul_done pulses that must be ignored.
        clear_mems();
        s0 = n_start;
        run_job(30, -1, -1, 1'b1, lat);
        check("start_pulses_job2", W'(n_start - s0), W'(1));
        check("idle_after_job2", W'(busy), W'(0));
        check_mem("a_contents_gaps", 1'b0);
        check_mem("b_contents_gaps", 1'b1);

        // Early in_last in operand A.
        clear_mems();
        s0 = n_start;
        run_job(0, 500, -1, 1'b0, lat);
        check("early_last_err", W'(err), W'(1));
        check("early_last_idle", W'(busy), W'(0));
        check("early_last_word", mem_a[4][62], W'(500));
        check("early_last_no_more", mem_a[5][62], '1);
        check("early_last_no_start", W'(n_start - s0), W'(0));

        @(posedge clk); #1;
        go = 1'b1;
        @(posedge clk); #1;
        go = 1'b0;
        @(negedge clk);
        check("go_clears_err", W'(err), W'(0));
        check("go_sets_busy", W'(busy), W'(1));

        // Reset at B index 200; the run_job go lands while busy and is ignored.
        run_job(0, -1, int'(N) + 200, 1'b0, lat);
        #1;
        w0 = n_wr;
        repeat (20) @(negedge clk);
        #1;
        check("writes_after_reset", W'(n_wr - w0), W'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/poly_bank_loader.md
POLY_BANK_LOADER -- requirements
Module: poly_bank_loader

Interface
REQ-001 Parameter N, default 1024: coefficients per polynomial.
REQ-002 Parameter BANKS, default 8: memory banks per operand.
REQ-003 Parameter DEPTH, default 128: words per bank (N = BANKS*DEPTH).
REQ-004 Parameter W, default 256: coefficient width in bits.
REQ-005 Port clk, input, 1: single clock; all logic on the rising edge.
REQ-006 Port rst, input, 1: reset is synchronous and active-high.
REQ-007 Port go, input, 1: single-cycle request to start one load-and-multiply job.
REQ-008 Port in_valid, input, 1: the stream coefficient is valid.
REQ-009 Port in_data, input, W: coefficient value.
REQ-010 Port in_last, input, 1: marks the final coefficient of the current operand.
REQ-011 Port in_ready, output, 1: loader accepts the coefficient this cycle.
REQ-012 Port wr_en_a, output, BANKS: one-hot write enable for the operand-A banks.
REQ-013 Port wr_en_b, output, BANKS: one-hot write enable for the operand-B banks.
REQ-014 Port wr_addr, output, log2(DEPTH): bank word address.
REQ-015 Port wr_data, output, W: bank write data.
REQ-016 Port mul_start, output, 1: start pulse to the polynomial multiplier.
REQ-017 Port mul_done, input, 1: completion from the multiplier.
REQ-018 Port busy, output, 1: a job is in progress (any state other than IDLE).
REQ-019 Port err, output, 1: sticky framing error, cleared by the next accepted go.

Function
REQ-020 The FSM SHALL have the states IDLE, LOAD_A, LOAD_B, START and WAIT_DONE.
REQ-021 IDLE->LOAD_A on go; the coefficient counter cnt is cleared to 0 and err is cleared.
REQ-022 in_ready SHALL be 1 only in LOAD_A and LOAD_B; a coefficient is accepted when in_valid && in_ready.
REQ-023 Coefficient index i SHALL map to bank i[2:0] and address i[9:3] (i mod BANKS, i div BANKS).
REQ-024 The bank write SHALL be registered: wr_en, wr_addr and wr_data are asserted exactly one cycle after acceptance, for one cycle.
REQ-025 In LOAD_A, writes SHALL use only wr_en_a; in LOAD_B, only wr_en_b; both enables are never nonzero together.
REQ-026 On acceptance with cnt == N-1, the FSM SHALL advance (LOAD_A->LOAD_B, or LOAD_B->START) and reset cnt to 0, whether or not in_last is set.
REQ-027 If in_last is accepted with cnt < N-1, the loader SHALL write that word, set err and return to IDLE; mul_start is not issued.
REQ-028 START SHALL assert mul_start for exactly one cycle and then move to WAIT_DONE; this cycle is entered only after the final B write has left the output registers.
REQ-029 WAIT_DONE->IDLE on mul_done; mul_done SHALL be ignored in every other state.
REQ-030 go SHALL be ignored while busy.
REQ-031 An N-coefficient operand with in_valid held high SHALL load in N cycles; the full job takes 2N+2 cycles from go to mul_start.
REQ-032 cnt SHALL be log2(N) bits wide with no wrap past N-1.

Reset
REQ-033 rst SHALL force IDLE, cnt=0, in_ready=0, wr_en_a=0, wr_en_b=0, wr_addr=0, wr_data=0, mul_start=0, busy=0 and err=0.
REQ-034 A reset during any state, including mid-load, SHALL abort the job with no further bank writes on the next cycle.

Structure
REQ-035 N, BANKS, DEPTH, W, the derived address widths and the FSM state encoding SHALL live in a shared package, poly_mul_pkg.
REQ-036 The block SHALL be a single module with no sub-modules; the bank memories stay in the multiplier top.

Verification
REQ-037 Stream A[i]=i, then B[i]=1000+i, with in_valid constant -> bank 3, address 5 of A holds 43; bank 7, address 127 of B holds 2023; mul_start pulses once, at cycle 2N+2 after go.
REQ-038 Random in_valid gaps (30% idle) -> bank contents identical to the back-to-back case; no write occurs in a cycle with no accepted word.
REQ-039 in_last at A index 500 -> index 500 is written, err=1, state returns to IDLE, mul_start never asserts; the next go clears err.
REQ-040 Assert rst at B index 200 -> all outputs are at reset values on the next cycle and no further writes occur.
REQ-041 go pulsed during LOAD_B and during WAIT_DONE, mul_done pulsed during LOAD_A -> all ignored; the job completes normally after mul_done in WAIT_DONE.
